// File: rtl/branch_resolve_predict.sv
// Execute-stage branch resolution for MIPS150 with a 2-bit saturating-counter
// predictor (direct-mapped) and saturating branch/mispredict statistics.
module branch_resolve_predict #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter bit          BYPASS      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     fetch_pc,
  output logic                 predict_taken,
  input  logic                 ex_valid,
  input  logic [WIDTH-1:0]     ex_pc,
  input  logic [5:0]           ex_opcode,
  input  logic [5:0]           ex_funct,
  input  logic [4:0]           ex_rt,
  input  logic [WIDTH-1:0]     ex_srca,
  input  logic [WIDTH-1:0]     ex_srcb,
  input  logic                 ex_predicted,
  output logic                 is_branch,
  output logic                 take_branch,
  output logic                 mispredict,
  input  logic                 stats_clr,
  output logic [CNT_WIDTH-1:0] br_count,
  output logic [CNT_WIDTH-1:0] mispred_count
);

  localparam int unsigned IDX = $clog2(BHT_ENTRIES);

  logic           is_cond, is_jump, cond_taken;
  logic           srca_neg, srca_zero, srcs_eq;
  logic [IDX-1:0] ex_idx, fetch_idx;
  logic [1:0]     ex_cnt, ex_cnt_upd, fetch_cnt;
  logic           bht_we;
  logic [1:0]     bht_q [BHT_ENTRIES];

  logic [CNT_WIDTH-1:0] br_q, mp_q;

  assign srca_neg  = ex_srca[WIDTH-1];
  assign srca_zero = (ex_srca == '0);
  assign srcs_eq   = (ex_srca == ex_srcb);

  always_comb begin
    is_cond    = 1'b0;
    is_jump    = 1'b0;
    cond_taken = 1'b0;
    if (ex_valid) begin
      case (ex_opcode)
        6'b000100: begin is_cond = 1'b1; cond_taken = srcs_eq;                end
        6'b000101: begin is_cond = 1'b1; cond_taken = !srcs_eq;               end
        6'b000110: begin is_cond = 1'b1; cond_taken = srca_neg | srca_zero;   end
        6'b000111: begin is_cond = 1'b1; cond_taken = !srca_neg & !srca_zero; end
        6'b000001: begin
          // rt[4] selects the linking variant and does not affect the condition
          if (ex_rt[3:1] == 3'b000) begin
            is_cond    = 1'b1;
            cond_taken = ex_rt[0] ? !srca_neg : srca_neg;
          end
        end
        6'b000010, 6'b000011: is_jump = 1'b1;
        6'b000000: begin
          if (ex_funct == 6'b001000 || ex_funct == 6'b001001) is_jump = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign is_branch   = is_cond | is_jump;
  assign take_branch = is_jump | (is_cond & cond_taken);
  assign mispredict  = is_branch & (take_branch != ex_predicted);

  assign ex_idx    = ex_pc[IDX+1:2];
  assign fetch_idx = fetch_pc[IDX+1:2];
  assign ex_cnt    = bht_q[ex_idx];
  assign bht_we    = is_cond & !rst;

  always_comb begin
    ex_cnt_upd = ex_cnt;
    if (cond_taken) begin
      if (ex_cnt != 2'd3) ex_cnt_upd = ex_cnt + 2'd1;
    end else begin
      if (ex_cnt != 2'd0) ex_cnt_upd = ex_cnt - 2'd1;
    end
  end

  always_comb begin
    fetch_cnt = bht_q[fetch_idx];
    if (BYPASS && bht_we && (ex_idx == fetch_idx)) fetch_cnt = ex_cnt_upd;
  end

  assign predict_taken = fetch_cnt[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (bht_we) begin
      bht_q[ex_idx] <= ex_cnt_upd;
    end
  end

  // Clear wins over a same-cycle increment; both counters stick at all-ones
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      if (is_branch && br_q != '1)  br_q <= br_q + CNT_WIDTH'(1);
      if (mispredict && mp_q != '1) mp_q <= mp_q + CNT_WIDTH'(1);
    end
  end

  assign br_count      = br_q;
  assign mispred_count = mp_q;

  logic unused_bits;
  assign unused_bits = ^{fetch_pc[1:0], fetch_pc[WIDTH-1:IDX+2], ex_pc[1:0],
                         ex_pc[WIDTH-1:IDX+2], ex_rt[4]};

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Randomised + directed bench for branch_resolve_predict; two instances (BYPASS=1, CNT_WIDTH=4
// and BYPASS=0, CNT_WIDTH=8) are checked every cycle against a behavioural model.
module tb_branch_resolve_predict;

  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_predicted, stats_clr;
  logic [31:0] fetch_pc, ex_pc, ex_srca, ex_srcb;
  logic [5:0]  ex_opcode, ex_funct;
  logic [4:0]  ex_rt;
  logic        pt_a, pt_b, isb_a, isb_b, tk_a, tk_b, mp_a, mp_b;
  logic [3:0]  brc_a, mpc_a;
  logic [7:0]  brc_b, mpc_b;

  int passed = 0, total = 0;

  // model state
  int bht [64];
  int m_br_a, m_mp_a, m_br_b, m_mp_b;

  always #5 clk = ~clk;

  branch_resolve_predict #(.WIDTH(32), .BHT_ENTRIES(64), .CNT_WIDTH(4), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .predict_taken(pt_a), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_funct(ex_funct), .ex_rt(ex_rt),
    .ex_srca(ex_srca), .ex_srcb(ex_srcb), .ex_predicted(ex_predicted), .is_branch(isb_a),
    .take_branch(tk_a), .mispredict(mp_a), .stats_clr(stats_clr), .br_count(brc_a),
    .mispred_count(mpc_a)
  );

  branch_resolve_predict #(.WIDTH(32), .BHT_ENTRIES(64), .CNT_WIDTH(8), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .predict_taken(pt_b), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_funct(ex_funct), .ex_rt(ex_rt),
    .ex_srca(ex_srca), .ex_srcb(ex_srcb), .ex_predicted(ex_predicted), .is_branch(isb_b),
    .take_branch(tk_b), .mispredict(mp_b), .stats_clr(stats_clr), .br_count(brc_b),
    .mispred_count(mpc_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  // Spec-level decode: returns branch / taken / conditional flags.
  function automatic void ref_decode(output bit br, output bit tk, output bit cond);
    int sa;
    sa = $signed(ex_srca);
    br = 0; tk = 0; cond = 0;
    if (!ex_valid) return;
    case (ex_opcode)
      6'd4: begin cond = 1; tk = (ex_srca == ex_srcb); end
      6'd5: begin cond = 1; tk = (ex_srca != ex_srcb); end
      6'd6: begin cond = 1; tk = (sa <= 0); end
      6'd7: begin cond = 1; tk = (sa > 0); end
      6'd1: if (ex_rt[3:1] == 3'd0) begin cond = 1; tk = ex_rt[0] ? (sa >= 0) : (sa < 0); end
      6'd2, 6'd3: tk = 1;
      6'd0: if (ex_funct == 6'd8 || ex_funct == 6'd9) tk = 1;
      default: ;
    endcase
    br = cond || (tk && !cond);
  endfunction

  function automatic int step_cnt(input int c, input bit tk);
    if (tk) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic compare();
    bit br, tk, cond, mp;
    int fi, ei, stored, post;
    ref_decode(br, tk, cond);
    mp = br && (tk != ex_predicted);
    chk("is_branch", {63'd0, isb_a}, {63'd0, br});
    chk("take_branch", {63'd0, tk_a}, {63'd0, tk});
    chk("mispredict", {63'd0, mp_a}, {63'd0, mp});
    chk("ex_outs_b", {61'd0, isb_b, tk_b, mp_b}, {61'd0, br, tk, mp});
    chk("br_count_a", {60'd0, brc_a}, 64'(m_br_a));
    chk("mispred_count_a", {60'd0, mpc_a}, 64'(m_mp_a));
    chk("br_count_b", {56'd0, brc_b}, 64'(m_br_b));
    chk("mispred_count_b", {56'd0, mpc_b}, 64'(m_mp_b));
    if (!rst) begin
      fi = (fetch_pc >> 2) % 64;
      ei = (ex_pc >> 2) % 64;
      stored = bht[fi];
      post = (cond && ei == fi) ? step_cnt(stored, tk) : stored;
      chk("predict_bypass", {63'd0, pt_a}, {63'd0, post >= 2});
      chk("predict_nobypass", {63'd0, pt_b}, {63'd0, stored >= 2});
    end
  endtask

  task automatic model_update();
    bit br, tk, cond, mp;
    ref_decode(br, tk, cond);
    mp = br && (tk != ex_predicted);
    if (rst) begin
      foreach (bht[i]) bht[i] = 1;
      m_br_a = 0; m_mp_a = 0; m_br_b = 0; m_mp_b = 0;
    end else begin
      if (cond) bht[(ex_pc >> 2) % 64] = step_cnt(bht[(ex_pc >> 2) % 64], tk);
      if (stats_clr) begin
        m_br_a = 0; m_mp_a = 0; m_br_b = 0; m_mp_b = 0;
      end else begin
        if (br) begin m_br_a = (m_br_a < 15) ? m_br_a + 1 : 15; m_br_b = (m_br_b < 255) ? m_br_b + 1 : 255; end
        if (mp) begin m_mp_a = (m_mp_a < 15) ? m_mp_a + 1 : 15; m_mp_b = (m_mp_b < 255) ? m_mp_b + 1 : 255; end
      end
    end
  endtask

  // Inputs are already driven; check mid-cycle, then advance one edge.
  task automatic cycle();
    #2;
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [5:0] op,
                       input logic [5:0] fn, input logic [4:0] rt, input logic [31:0] a,
                       input logic [31:0] b, input logic pred);
    ex_valid = v; ex_pc = pc; ex_opcode = op; ex_funct = fn; ex_rt = rt;
    ex_srca = a; ex_srcb = b; ex_predicted = pred;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'(($urandom_range(0, 3)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] ops [10];
    ops = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd2, 6'd3, 6'd0, 6'd8, 6'd0};

    rst = 1'b1; stats_clr = 1'b0; fetch_pc = '0;
    drive(1'b0, 32'h0, 6'd0, 6'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    @(posedge clk); model_update(); #1;
    @(posedge clk); model_update(); #1;
    rst = 1'b0;

    // Reset sweep: weakly not-taken everywhere
    for (int i = 0; i < 64; i++) begin
      fetch_pc = 32'(i * 4);
      cycle();
    end
    chk("pin_reset_ctr", 64'(bht[17]), 64'd1);
    chk("pin_reset_brc", {60'd0, brc_a}, 64'd0);

    // beq x3 at 0x100, taken, predicted not-taken
    fetch_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100, 6'd4, 6'd0, 5'd0, 32'd5, 32'd5, 1'b0);
      if (i == 0) begin
        #2;
        chk("pin_bypass_same_cycle", {63'd0, pt_a}, 64'd1);
        chk("pin_nobypass_same_cycle", {63'd0, pt_b}, 64'd0);
        #0 cycle();
        chk("pin_nobypass_next_cycle_model", 64'(bht[0]), 64'd2);
      end else cycle();
    end
    drive(1'b0, 32'h100, 6'd0, 6'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    cycle();
    chk("pin_ctr_sat3", 64'(bht[0]), 64'd3);
    chk("pin_br3", {60'd0, brc_a}, 64'd3);
    chk("pin_mp3", {60'd0, mpc_a}, 64'd3);
    chk("pin_pred_0x100", {63'd0, pt_b}, 64'd1);

    // Signed boundaries
    fetch_pc = 32'h40;
    drive(1'b1, 32'h40, 6'd1, 6'd0, 5'd0, 32'h8000_0000, 32'd0, 1'b0);
    #1 chk("pin_bltz_min", {63'd0, tk_a}, 64'd1);
    cycle();
    drive(1'b1, 32'h40, 6'd1, 6'd0, 5'd1, 32'h8000_0000, 32'd0, 1'b0);
    #1 chk("pin_bgez_min", {63'd0, tk_a}, 64'd0);
    cycle();
    drive(1'b1, 32'h40, 6'd6, 6'd0, 5'd0, 32'h8000_0000, 32'd0, 1'b0); cycle();
    drive(1'b1, 32'h40, 6'd7, 6'd0, 5'd0, 32'h0, 32'd0, 1'b0);         cycle();
    drive(1'b1, 32'h40, 6'd1, 6'd0, 5'd2, 32'h8000_0000, 32'd0, 1'b0);
    #1 chk("pin_regimm_bad_rt", {63'd0, isb_a}, 64'd0);
    cycle();

    // Jumps and an unknown opcode
    fetch_pc = 32'h80;
    drive(1'b1, 32'h80, 6'd0, 6'd8, 5'd0, 32'd0, 32'd0, 1'b0); cycle();
    drive(1'b1, 32'h80, 6'd0, 6'd9, 5'd0, 32'd0, 32'd0, 1'b0); cycle();
    drive(1'b1, 32'h80, 6'd2, 6'd0, 5'd0, 32'd0, 32'd0, 1'b0); cycle();
    drive(1'b1, 32'h80, 6'd3, 6'd0, 5'd0, 32'd0, 32'd0, 1'b0); cycle();
    drive(1'b1, 32'h80, 6'd8, 6'd0, 5'd0, 32'd0, 32'd0, 1'b1); cycle();
    chk("pin_jump_no_train", 64'(bht[32]), 64'd1);

    // Saturation on the 4-bit counters
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h200, 6'd4, 6'd0, 5'd0, 32'd1, 32'd2, 1'b1);
      cycle();
    end
    drive(1'b0, 32'h200, 6'd4, 6'd0, 5'd0, 32'd1, 32'd1, 1'b0); cycle();
    chk("pin_br_sat", {60'd0, brc_a}, 64'd15);
    chk("pin_mp_sat", {60'd0, mpc_a}, 64'd15);
    stats_clr = 1'b1;
    drive(1'b1, 32'h200, 6'd4, 6'd0, 5'd0, 32'd1, 32'd2, 1'b1); cycle();
    stats_clr = 1'b0;
    drive(1'b0, 32'h200, 6'd4, 6'd0, 5'd0, 32'd1, 32'd1, 1'b0); cycle();
    chk("pin_clr_priority", {56'd0, brc_b}, 64'd0);
    cycle();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc;
      logic [5:0]  op;
      pc = 32'h100 + 32'($urandom_range(0, 7) * 4) + (($urandom_range(0, 3) == 0) ? 32'h100 : 32'h0);
      op = ops[$urandom_range(0, 9)];
      drive(($urandom_range(0, 9) < 8), pc, op,
            ($urandom_range(0, 1) ? 6'd8 + 6'($urandom_range(0, 1)) : 6'($urandom)),
            5'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 1) | ($urandom_range(0, 1) << 4)),
            rand_operand(), ($urandom_range(0, 2) == 0) ? rand_operand() : 32'(ex_srca),
            1'($urandom));
      if (ex_srcb == 32'(ex_srca) && $urandom_range(0, 1)) ex_srcb = rand_operand();
      fetch_pc = $urandom_range(0, 1) ? pc : 32'h100 + 32'($urandom_range(0, 15) * 4);
      rst = ($urandom_range(0, 199) == 0);
      stats_clr = ($urandom_range(0, 39) == 0);
      cycle();
    end
    rst = 1'b0; stats_clr = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/branch_resolve_predict.md
# branch_resolve_predict

Parametrised branch unit for the MIPS150 pipeline: resolves every control-transfer instruction in the execute stage and supplies a taken/not-taken prediction to fetch. It evaluates the branch condition and flags mispredictions against the fetch-time guess. It also trains a direct-mapped table of 2-bit saturating counters and keeps saturating branch and mispredict statistics counters.

## Interface
Parameters:
- WIDTH, 32, operand and PC width
- BHT_ENTRIES, 64, predictor entries; power of two, at least 2; IDX = log2(BHT_ENTRIES)
- CNT_WIDTH, 32, statistics counter width
- BYPASS, 1, 1 = same-cycle update forwarded to fetch read; 0 = fetch sees pre-update value

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- fetch_pc  in  WIDTH  PC being fetched
- predict_taken  out  1  prediction for fetch_pc
- ex_valid  in  1  execute-stage instruction valid (low during stall/bubble)
- ex_pc  in  WIDTH  PC of execute-stage instruction
- ex_opcode  in  6  opcode
- ex_funct  in  6  funct
- ex_rt  in  5  rt field
- ex_srca  in  WIDTH  rs value
- ex_srcb  in  WIDTH  rt value
- ex_predicted  in  1  prediction carried down from fetch
- is_branch  out  1  valid control-transfer instruction in execute
- take_branch  out  1  resolved direction
- mispredict  out  1  is_branch & (take_branch != ex_predicted)
- stats_clr  in  1  clear statistics counters
- br_count  out  CNT_WIDTH  resolved control transfers
- mispred_count  out  CNT_WIDTH  mispredictions

## Operation
Instruction decode is qualified by ex_valid. All comparisons are signed on WIDTH bits.
- beq 000100: taken when srca == srcb.
- bne 000101: taken when srca != srcb.
- blez 000110: taken when srca <= 0.
- bgtz 000111: taken when srca > 0.
- REGIMM 000001:
  - ex_rt[0]=0 (bltz, bltzal): taken when srca < 0.
  - ex_rt[0]=1 (bgez, bgezal): taken when srca >= 0.
  - Any other ex_rt[3:1] value: not a branch.
- j 000010, jal 000011: always taken.
- opcode 000000 with funct 001000 (jr) or 001001 (jalr): always taken.
- All other encodings: is_branch=0, take_branch=0, mispredict=0.
- Only the six conditional classes above are "conditional"; jumps are unconditional.

Predictor:
- Index = pc[IDX+1:2]. Counter value >= 2'b10 means predict taken.
- predict_taken = (counter[fetch_pc index] >= 2) OR fetch_pc aliases an unconditional entry. There is no such aliasing: jumps never train the table, so fetch prediction comes from the counter alone.
- Update on posedge when ex_valid & conditional: taken increments the counter, saturating at 3; not-taken decrements it, saturating at 0.
- Unconditional transfers never touch the table.
- BYPASS=1: if the updating index equals the fetch index in the same cycle, predict_taken uses the post-update value. BYPASS=0: it uses the stored value.

Statistics:
- br_count increments on each is_branch cycle.
- mispred_count increments on each mispredict cycle.
- Both saturate at all-ones.
- stats_clr sets both counters to 0 and has priority over a same-cycle increment.

## Timing
- is_branch, take_branch and mispredict are combinational from the ex_* inputs, with zero latency.
- predict_taken is combinational from fetch_pc and the table.
- The table update and statistics become visible at the next posedge; readers see them on the cycle after.
- Reset (synchronous):
  - All counters go to 2'b01 (weakly not-taken).
  - br_count and mispred_count go to 0.
  - Resulting output values: predict_taken=0 for every PC, and combinational outputs follow their inputs.
- Reset mid-operation: table and statistics are cleared at that edge. An update or increment requested in the same cycle is discarded.
- Stall: with ex_valid=0 there is no update, no increment, and all ex-side outputs are 0.
- Back-to-back updates to the same index accumulate one step per cycle.

## Test plan
- Reset, then sweep fetch_pc over all BHT_ENTRIES indices -> predict_taken=0 everywhere; br_count=0; mispred_count=0.
- beq at ex_pc=0x100 with srca=srcb=5, ex_predicted=0, issued on three consecutive cycles:
  - Each cycle: take_branch=1, mispredict=1.
  - Counter sequence 1→2→3; predict_taken for 0x100 becomes 1 after the first edge.
  - After the edges: br_count=3, mispred_count=3.
- Signed boundaries with srca=0x80000000:
  - bltz (rt=0) -> taken.
  - bgez (rt=1) -> not taken.
  - blez -> taken.
  - bgtz with srca=0 -> not taken.
  - REGIMM with rt=00010 -> is_branch=0.
- jr, jalr, j and jal with ex_predicted=0 -> take_branch=1, mispredict=1, and the table is unchanged. An unknown opcode (e.g. 001000 addi) -> all outputs 0.
- BYPASS=1 vs BYPASS=0: counter at 1, taken update while fetch_pc has the same index -> predict_taken=1 in the same cycle for BYPASS=1; 0 for BYPASS=0, then 1 on the next cycle.
- Stats saturation and clear with CNT_WIDTH=4:
  - 20 mispredicts -> both counters hold 15.
  - stats_clr together with a mispredict -> both read 0 next cycle.
  - ex_valid=0 with a beq present -> no change.
